mbist_mem_if_cmp: RTL and testbench

// - Downstream stage of the PMBIST microcode_container.
// - Turns each {op_cmd, addr_x, addr_y, data} into registered SRAM port controls:
//   WE, RE, OE, address and write data.
// - Delays the expected read data to match the memory read latency, then

---
 rtl/pmbist_pkg.sv | 19 +
 rtl/mbist_exp_pipe.sv | 37 +++
 rtl/mbist_mem_if_cmp.sv | 190 +++++++++++++++++++
 tb/tb_mbist_mem_if_cmp.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pmbist_pkg.sv
// Shared PMBIST types: microcode op encoding and mem-interface FSM states.
package pmbist;

    // Op command from microcode_container; encoding 2'b11 is unused and treated as NOP.
    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2
    } t_op_cmd;

    // Memory-interface / compare FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } t_mem_if_state;

endpackage

// File: rtl/mbist_exp_pipe.sv
// Valid-tagged shift register carrying {exp, ax, ay} of each issued READ
// until its Q is available. The oldest stage feeds the comparator.
module mbist_exp_pipe #(
    parameter int DEPTH = 2,
    parameter int W     = 6
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    output logic         o_vld,
    output logic [W-1:0] o_data,
    output logic         o_busy
);

    logic [DEPTH-1:0]        r_vld;
    logic [DEPTH-1:0][W-1:0] r_data;

    // Shift one stage per cycle; flush only drops valids, payload is don't-care.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld  <= '0;
            r_data <= '0;
        end else begin
            if (i_flush) r_vld <= '0;
            else         r_vld <= {r_vld[DEPTH-2:0], i_push};
            r_data <= {r_data[DEPTH-2:0], i_data};
        end
    end

    assign o_vld  = r_vld[DEPTH-1];
    assign o_data = r_data[DEPTH-1];
    // Busy ignores the oldest stage: that entry is being compared this cycle.
    assign o_busy = |r_vld[DEPTH-2:0];

endmodule

// File: rtl/mbist_mem_if_cmp.sv
// PMBIST memory interface: registers SRAM port controls from microcode ops,
// aligns expected read data to the read latency, compares against Q and
// keeps sticky fail status, first-fail record and a saturating fail count.
module mbist_mem_if_cmp
    import pmbist::*;
#(
    parameter int AX_WIDTH   = 2,
    parameter int AY_WIDTH   = 2,
    parameter int D_WIDTH    = 2,
    parameter int RD_LAT     = 1,
    parameter int FCNT_WIDTH = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_mbist_run,
    input  t_op_cmd                      i_op_cmd,
    input  logic [AX_WIDTH-1:0]          i_addr_x,
    input  logic [AY_WIDTH-1:0]          i_addr_y,
    input  logic [D_WIDTH-1:0]           i_data,
    input  logic                         i_end_of_prog,
    output logic                         o_mem_we,
    output logic                         o_mem_re,
    output logic                         o_mem_oe,
    output logic [AX_WIDTH+AY_WIDTH-1:0] o_mem_a,
    output logic [D_WIDTH-1:0]           o_mem_d,
    input  logic [D_WIDTH-1:0]           i_mem_q,
    output logic                         o_fail,
    output logic [FCNT_WIDTH-1:0]        o_fail_cnt,
    output logic [AX_WIDTH-1:0]          o_fail_addr_x,
    output logic [AY_WIDTH-1:0]          o_fail_addr_y,
    output logic [D_WIDTH-1:0]           o_fail_exp,
    output logic [D_WIDTH-1:0]           o_fail_act,
    output logic                         o_done
);

    localparam int AW = AX_WIDTH + AY_WIDTH;
    localparam int PW = D_WIDTH + AX_WIDTH + AY_WIDTH;

    typedef struct packed {
        logic [AX_WIDTH-1:0] ax;
        logic [AY_WIDTH-1:0] ay;
        logic [D_WIDTH-1:0]  exp;
        logic [D_WIDTH-1:0]  act;
    } t_fail_rec;

    t_mem_if_state           r_state;
    logic                    r_run_d;
    logic                    r_we, r_re, r_oe, r_done;
    logic [AW-1:0]           r_a;
    logic [D_WIDTH-1:0]      r_d;
    logic                    r_fail;
    logic [FCNT_WIDTH-1:0]   r_cnt;
    t_fail_rec               r_rec;

    logic                    w_start, w_abort, w_push;
    logic                    w_pipe_vld, w_pipe_busy, w_mis;
    logic [PW-1:0]           w_pipe_data;
    logic [D_WIDTH-1:0]      w_exp;
    logic [AX_WIDTH-1:0]     w_ax;
    logic [AY_WIDTH-1:0]     w_ay;

    assign w_start = i_mbist_run & ~r_run_d;
    assign w_abort = ~i_mbist_run & ((r_state == RUN) | (r_state == DRAIN));
    assign w_push  = (r_state == RUN) & i_mbist_run & (i_op_cmd == OP_READ);

    mbist_exp_pipe #(
        .DEPTH (RD_LAT + 1),
        .W     (PW)
    ) u_exp_pipe (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (w_abort),
        .i_push  (w_push),
        .i_data  ({i_data, i_addr_x, i_addr_y}),
        .o_vld   (w_pipe_vld),
        .o_data  (w_pipe_data),
        .o_busy  (w_pipe_busy)
    );

    assign w_exp = w_pipe_data[PW-1 -: D_WIDTH];
    assign w_ax  = w_pipe_data[AW-1 -: AX_WIDTH];
    assign w_ay  = w_pipe_data[AY_WIDTH-1:0];
    // An entry leaving the pipe on an abort edge counts as flushed.
    assign w_mis = w_pipe_vld & ~w_abort & (i_mem_q != w_exp);

    // Session FSM with registered memory-port controls and done flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_run_d <= 1'b0;
            r_we    <= 1'b0;
            r_re    <= 1'b0;
            r_oe    <= 1'b0;
            r_done  <= 1'b0;
            r_a     <= '0;
            r_d     <= '0;
        end else begin
            r_run_d <= i_mbist_run;
            r_we    <= 1'b0;
            r_re    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= RUN;
                        r_oe    <= 1'b1;
                    end
                end
                RUN: begin
                    if (!i_mbist_run) begin
                        r_state <= IDLE;
                        r_oe    <= 1'b0;
                        r_a     <= '0;
                        r_d     <= '0;
                    end else begin
                        case (i_op_cmd)
                            OP_WRITE: begin
                                r_we <= 1'b1;
                                r_a  <= {i_addr_x, i_addr_y};
                                r_d  <= i_data;
                            end
                            OP_READ: begin
                                r_re <= 1'b1;
                                r_a  <= {i_addr_x, i_addr_y};
                            end
                            default: ;
                        endcase
                        if (i_end_of_prog) r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!i_mbist_run) begin
                        r_state <= IDLE;
                        r_oe    <= 1'b0;
                        r_a     <= '0;
                        r_d     <= '0;
                    end else if (!w_pipe_busy) begin
                        r_state <= DONE;
                        r_oe    <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (!i_mbist_run) begin
                        r_state <= IDLE;
                        r_done  <= 1'b0;
                        r_a     <= '0;
                        r_d     <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_oe    <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Fail status: cleared on session start, sticky flag, saturating count,
    // record captured only on the first mismatch of a session.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fail <= 1'b0;
            r_cnt  <= '0;
            r_rec  <= '0;
        end else if ((r_state == IDLE) && w_start) begin
            r_fail <= 1'b0;
            r_cnt  <= '0;
            r_rec  <= '0;
        end else if (w_mis) begin
            r_fail <= 1'b1;
            if (r_cnt != '1) r_cnt <= r_cnt + FCNT_WIDTH'(1);
            if (!r_fail) r_rec <= '{ax: w_ax, ay: w_ay, exp: w_exp, act: i_mem_q};
        end
    end

    assign o_mem_we      = r_we;
    assign o_mem_re      = r_re;
    assign o_mem_oe      = r_oe;
    assign o_mem_a       = r_a;
    assign o_mem_d       = r_d;
    assign o_fail        = r_fail;
    assign o_fail_cnt    = r_cnt;
    assign o_fail_addr_x = r_rec.ax;
    assign o_fail_addr_y = r_rec.ay;
    assign o_fail_exp    = r_rec.exp;
    assign o_fail_act    = r_rec.act;
    assign o_done        = r_done;

endmodule

// File: tb/tb_mbist_mem_if_cmp.sv
// Directed bench: two instances share stimulus, one at RD_LAT=1 with a 2-bit
// fail counter, one at RD_LAT=3 with an 8-bit counter, each on its own
// 16x2 synchronous SRAM model.
module tb_mbist_mem_if_cmp;
    import pmbist::*;

    logic       clk = 1'b0;
    logic       rst, run, eop;
    t_op_cmd    op;
    logic [1:0] ax, ay, dat;

    logic       we1, re1, oe1, fail1, done1, fx1_dummy;
    logic [3:0] a1;
    logic [1:0] d1, q1, cnt1, fx1, fy1, fe1, fa1;
    logic       we3, re3, oe3, fail3, done3;
    logic [3:0] a3;
    logic [1:0] d3, q3, fx3, fy3, fe3, fa3;
    logic [7:0] cnt3;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mbist_mem_if_cmp #(.AX_WIDTH(2), .AY_WIDTH(2), .D_WIDTH(2), .RD_LAT(1), .FCNT_WIDTH(2)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_mbist_run(run), .i_op_cmd(op),
        .i_addr_x(ax), .i_addr_y(ay), .i_data(dat), .i_end_of_prog(eop),
        .o_mem_we(we1), .o_mem_re(re1), .o_mem_oe(oe1), .o_mem_a(a1), .o_mem_d(d1),
        .i_mem_q(q1), .o_fail(fail1), .o_fail_cnt(cnt1), .o_fail_addr_x(fx1),
        .o_fail_addr_y(fy1), .o_fail_exp(fe1), .o_fail_act(fa1), .o_done(done1));

    mbist_mem_if_cmp #(.AX_WIDTH(2), .AY_WIDTH(2), .D_WIDTH(2), .RD_LAT(3), .FCNT_WIDTH(8)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_mbist_run(run), .i_op_cmd(op),
        .i_addr_x(ax), .i_addr_y(ay), .i_data(dat), .i_end_of_prog(eop),
        .o_mem_we(we3), .o_mem_re(re3), .o_mem_oe(oe3), .o_mem_a(a3), .o_mem_d(d3),
        .i_mem_q(q3), .o_fail(fail3), .o_fail_cnt(cnt3), .o_fail_addr_x(fx3),
        .o_fail_addr_y(fy3), .o_fail_exp(fe3), .o_fail_act(fa3), .o_done(done3));

    // SRAM models: RE sampled at an edge, Q valid RD_LAT edges later.
    logic [1:0] mem1 [16];
    logic [1:0] mem3 [16];
    logic [1:0] qp3  [3];

    always @(posedge clk) begin
        if (we1) mem1[a1] <= d1;
        if (re1) q1 <= mem1[a1];
    end

    always @(posedge clk) begin
        if (we3) mem3[a3] <= d3;
        if (re3) qp3[0] <= mem3[a3];
        qp3[1] <= qp3[0];
        qp3[2] <= qp3[1];
    end
    assign q3 = qp3[2];
    assign fx1_dummy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input t_op_cmd c, input int x, input int y, input int d, input logic e);
        op  = c;
        ax  = 2'(x);
        ay  = 2'(y);
        dat = 2'(d);
        eop = e;
    endtask

    task automatic mop(input t_op_cmd c, input int addr, input logic [1:0] d, input logic e);
        drv(c, addr / 4, addr % 4, int'(d), e);
        tick();
    endtask

    logic [1:0] bg;
    logic [1:0] illegal_code;

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem1[i] = 2'b00;
            mem3[i] = 2'b00;
        end
        q1 = 2'b00;
        for (int i = 0; i < 3; i++) qp3[i] = 2'b00;
        rst = 1'b1; run = 1'b0;
        drv(OP_NOP, 0, 0, 0, 1'b0);
        tick(); tick();
        // reset state
        chk("rst_oe1", 32'(oe1), 0);
        chk("rst_a1", 32'(a1), 0);
        chk("rst_fail1", 32'(fail1), 0);
        chk("rst_done3", 32'(done3), 0);
        rst = 1'b0;
        tick();

        // session start
        run = 1'b1; tick();
        chk("start_oe1", 32'(oe1), 1);
        chk("start_oe3", 32'(oe3), 1);

        // write then matching read
        drv(OP_WRITE, 1, 2, 3, 1'b0); tick();
        chk("wr_we", 32'(we1), 1);
        chk("wr_a", 32'(a1), 32'h6);
        chk("wr_d", 32'(d1), 3);
        drv(OP_READ, 1, 2, 3, 1'b0); tick();
        chk("rd_re", 32'(re1), 1);
        chk("rd_we", 32'(we1), 0);
        drv(OP_NOP, 0, 0, 0, 1'b0); tick();
        chk("nop_hold_a", 32'(a1), 32'h6);
        chk("nop_re", 32'(re1), 0);
        illegal_code = 2'b11;
        op = t_op_cmd'(illegal_code); ax = 2'd0; ay = 2'd0; dat = 2'd0; tick();
        chk("ill_we", 32'(we1), 0);
        chk("ill_re", 32'(re1), 0);
        chk("ill_hold_a", 32'(a1), 32'h6);
        drv(OP_NOP, 0, 0, 0, 1'b0); tick(); tick(); tick();
        chk("match_fail1", 32'(fail1), 0);
        chk("match_fail3", 32'(fail3), 0);

        // first mismatch: mem(3,1)=1, expect 0
        drv(OP_WRITE, 3, 1, 1, 1'b0); tick();
        drv(OP_READ, 3, 1, 0, 1'b0); tick();
        drv(OP_NOP, 0, 0, 0, 1'b0); tick();
        chk("mis_early1", 32'(fail1), 0);
        tick();
        chk("mis_fail1", 32'(fail1), 1);
        chk("mis_rec1", {fx1, fy1, fe1, fa1}, {2'd3, 2'd1, 2'd0, 2'd1});
        chk("mis_cnt1", 32'(cnt1), 1);
        chk("mis_early3", 32'(fail3), 0);
        tick(); tick();
        chk("mis_fail3", 32'(fail3), 1);
        chk("mis_rec3", {fx3, fy3, fe3, fa3}, {2'd3, 2'd1, 2'd0, 2'd1});
        // second mismatch: mem(1,2)=3, expect 0
        drv(OP_READ, 1, 2, 0, 1'b0); tick();
        drv(OP_NOP, 0, 0, 0, 1'b0); tick(); tick();
        chk("mis2_cnt1", 32'(cnt1), 2);
        chk("mis2_rec1", {fx1, fy1, fe1, fa1}, {2'd3, 2'd1, 2'd0, 2'd1});
        tick(); tick();
        chk("mis2_cnt3", 32'(cnt3), 2);

        // abort with two mismatching reads in flight
        drv(OP_READ, 1, 2, 0, 1'b0); tick();
        drv(OP_READ, 3, 1, 0, 1'b0); tick();
        run = 1'b0; drv(OP_NOP, 0, 0, 0, 1'b0); tick();
        chk("abt_re1", 32'(re1), 0);
        chk("abt_oe1", 32'(oe1), 0);
        chk("abt_a1", 32'(a1), 0);
        chk("abt_done1", 32'(done1), 0);
        tick(); tick(); tick();
        chk("abt_cnt1", 32'(cnt1), 2);
        chk("abt_cnt3", 32'(cnt3), 2);
        chk("abt_done3", 32'(done3), 0);
        run = 1'b1; tick();
        chk("restart_fail1", 32'(fail1), 0);
        chk("restart_cnt1", 32'(cnt1), 0);
        chk("restart_rec1", {fx1, fy1, fe1, fa1}, 0);
        chk("restart_cnt3", 32'(cnt3), 0);

        // five back-to-back mismatches
        for (int i = 0; i < 5; i++) begin
            drv(OP_READ, 1, 2, 0, 1'b0); tick();
        end
        drv(OP_NOP, 0, 0, 0, 1'b0); tick(); tick(); tick(); tick();
        chk("sat_cnt1", 32'(cnt1), 3);
        chk("sat_cnt3", 32'(cnt3), 5);
        chk("sat_rec1", {fx1, fy1, fe1, fa1}, {2'd1, 2'd2, 2'd0, 2'd3});

        // end_of_prog with the last read
        drv(OP_READ, 3, 1, 0, 1'b1); tick();
        drv(OP_NOP, 0, 0, 0, 1'b0); tick();
        chk("eop_done1_k1", 32'(done1), 0);
        chk("eop_re3", 32'(re3), 0);
        chk("eop_oe3", 32'(oe3), 1);
        tick();
        chk("eop_done1", 32'(done1), 1);
        chk("eop_oe1", 32'(oe1), 0);
        tick();
        chk("eop_done3_k3", 32'(done3), 0);
        chk("eop_cnt3_k3", 32'(cnt3), 5);
        tick();
        chk("eop_done3", 32'(done3), 1);
        chk("eop_cnt3", 32'(cnt3), 6);
        chk("eop_oe3_done", 32'(oe3), 0);
        tick();
        chk("done_hold3", 32'(done3), 1);
        run = 1'b0; tick();
        chk("idle_done3", 32'(done3), 0);
        chk("idle_keep_cnt3", 32'(cnt3), 6);
        chk("idle_keep_fail1", 32'(fail1), 1);

        // async reset mid-run with a read outstanding
        run = 1'b1; tick();
        drv(OP_READ, 1, 2, 0, 1'b0); tick();
        drv(OP_READ, 3, 1, 0, 1'b0); tick();
        drv(OP_NOP, 0, 0, 0, 1'b0); tick();
        chk("pre_rst_fail1", 32'(fail1), 1);
        rst = 1'b1; #1;
        chk("arst_fail1", 32'(fail1), 0);
        chk("arst_cnt1", 32'(cnt1), 0);
        chk("arst_oe1", 32'(oe1), 0);
        chk("arst_a1", 32'(a1), 0);
        chk("arst_rec1", {fx1, fy1, fe1, fa1}, 0);
        run = 1'b0;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("post_rst_fail1", 32'(fail1), 0);
        chk("post_rst_fail3", 32'(fail3), 0);
        chk("post_rst_cnt3", 32'(cnt3), 0);

        // MARCH-X, both data backgrounds, fault-free memories
        run = 1'b1; tick();
        for (int b = 0; b < 2; b++) begin
            bg = (b == 0) ? 2'b00 : 2'b11;
            for (int i = 0; i < 16; i++) mop(OP_WRITE, i, bg, 1'b0);
            for (int i = 0; i < 16; i++) begin
                mop(OP_READ, i, bg, 1'b0);
                mop(OP_WRITE, i, ~bg, 1'b0);
            end
            for (int i = 15; i >= 0; i--) begin
                mop(OP_READ, i, ~bg, 1'b0);
                mop(OP_WRITE, i, bg, 1'b0);
            end
            for (int i = 0; i < 16; i++) mop(OP_READ, i, bg, (b == 1) && (i == 15));
        end
        drv(OP_NOP, 0, 0, 0, 1'b0);
        for (int i = 0; i < 20 && !(done1 && done3); i++) tick();
        chk("march_done1", 32'(done1), 1);
        chk("march_done3", 32'(done3), 1);
        chk("march_fail1", 32'(fail1), 0);
        chk("march_fail3", 32'(fail3), 0);
        chk("march_cnt3", 32'(cnt3), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
